// File: rtl/rv_id_decode_if.sv
// Fetch-to-decode and decode-to-EX beat signals for rv_id_decode.
// master: the fetch/EX side that offers beats and consumes decoded results.
// slave:  the decode stage itself.
interface rv_id_decode_if #(
  parameter int unsigned XLEN = 32
) ();

  // Fetch side
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  // EX side
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_instr;
  logic [4:0]      ex_rs1_addr;
  logic [4:0]      ex_rs2_addr;
  logic [4:0]      ex_rd_addr;
  logic [31:0]     ex_imm;
  logic [2:0]      ex_funct3;
  logic            ex_funct7_r;
  logic [3:0]      ex_op_class;
  logic            ex_illegal;

  modport master (
    output if_valid, if_pc, if_instr, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_instr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
    input  ex_imm, ex_funct3, ex_funct7_r, ex_op_class, ex_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_instr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
    output ex_imm, ex_funct3, ex_funct7_r, ex_op_class, ex_illegal
  );

endinterface

// File: rtl/rv_id_decode.sv
// RV32I instruction-decode stage with valid/ready handshake.
// Output pipeline register plus a one-entry skid buffer so if_ready comes straight from a flop.
// Optional illegal-instruction checking is enabled by defining RV_ID_ILLEGAL_CHK_EN; without it
// ex_illegal is tied 0 and unknown opcodes decode as the NOP class.
module rv_id_decode #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  rv_id_decode_if.slave bus
);

  // Major opcodes
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  // Operation classes seen by EX
  localparam logic [3:0] ClsOp      = 4'd0;
  localparam logic [3:0] ClsOpImm   = 4'd1;
  localparam logic [3:0] ClsLoad    = 4'd2;
  localparam logic [3:0] ClsStore   = 4'd3;
  localparam logic [3:0] ClsBranch  = 4'd4;
  localparam logic [3:0] ClsJal     = 4'd5;
  localparam logic [3:0] ClsJalr    = 4'd6;
  localparam logic [3:0] ClsLui     = 4'd7;
  localparam logic [3:0] ClsAuipc   = 4'd8;
  localparam logic [3:0] ClsNop     = 4'd9;
  localparam logic [3:0] ClsIllegal = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [2:0]      funct3;
    logic            funct7_r;
    logic [3:0]      op_class;
    logic            illegal;
  } beat_t;

  // Contents of an empty output/skid slot
  localparam beat_t Bubble = '{instr: NOP_INSTR, default: '0};

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e state_q, state_d;
  beat_t  out_q, out_d;
  beat_t  skid_q, skid_d;
  logic   if_ready_q, if_ready_d;

  logic   accept, retire, ex_valid;
  beat_t  dec;

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  cls;
  logic [31:0] imm;
  logic        f7r;
  logic        ill;

  assign ins    = bus.if_instr[31:0];
  assign opcode = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];

  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_sh = {27'b0, ins[24:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Combinational decode of the beat currently offered by fetch
  always_comb begin
    cls = ClsNop;
    imm = '0;
    f7r = 1'b0;
    ill = 1'b0;
    case (opcode)
      OpcOp: begin
        cls = ClsOp;
        f7r = ins[30];
        ill = !((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OpcOpImm: begin
        cls = ClsOpImm;
        if (f3 == 3'b001) begin
          imm = imm_sh;
          ill = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          imm = imm_sh;
          f7r = ins[30];
          ill = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
        end else begin
          imm = imm_i;
        end
      end
      OpcLoad: begin
        cls = ClsLoad;
        imm = imm_i;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OpcStore: begin
        cls = ClsStore;
        imm = imm_s;
        ill = (f3 > 3'b010);
      end
      OpcBranch: begin
        cls = ClsBranch;
        imm = imm_b;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OpcJal: begin
        cls = ClsJal;
        imm = imm_j;
      end
      OpcJalr: begin
        cls = ClsJalr;
        imm = imm_i;
        ill = (f3 != 3'b000);
      end
      OpcLui: begin
        cls = ClsLui;
        imm = imm_u;
      end
      OpcAuipc: begin
        cls = ClsAuipc;
        imm = imm_u;
      end
      OpcFence, OpcSystem: cls = ClsNop;
      default: begin
        cls = ClsNop;
        ill = 1'b1;
      end
    endcase
`ifdef RV_ID_ILLEGAL_CHK_EN
    // Compressed/invalid length encodings never match a 32-bit opcode, but flag them explicitly
    if (ins[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin
      cls = ClsIllegal;
      imm = '0;
      f7r = 1'b0;
    end
`else
    ill = 1'b0;
`endif

    dec          = Bubble;
    dec.pc       = bus.if_pc;
    dec.instr    = bus.if_instr;
    dec.rs1      = ins[19:15];
    dec.rs2      = ins[24:20];
    dec.imm      = imm;
    dec.funct3   = f3;
    dec.funct7_r = f7r;
    dec.op_class = cls;
    dec.illegal  = ill;
    // Classes that never write a register carry rd=0 so EX needs no extra qualification
    if ((cls == ClsStore) || (cls == ClsBranch) || (cls == ClsNop) || (cls == ClsIllegal)) begin
      dec.rd = 5'd0;
    end else begin
      dec.rd = ins[11:7];
    end
  end

  assign ex_valid = (state_q != StEmpty);
  assign accept   = bus.if_valid & if_ready_q;
  assign retire   = ex_valid & bus.ex_ready;

  // Next-state for the output register / skid buffer pair
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    skid_d     = skid_q;
    if_ready_d = if_ready_q;
    if (flush) begin
      // Any retire this cycle has already been taken by EX; everything else is dropped
      state_d    = StEmpty;
      out_d      = Bubble;
      skid_d     = Bubble;
      if_ready_d = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StFull;
            out_d   = dec;
          end
        end
        StFull: begin
          if (accept && !retire) begin
            state_d    = StSkid;
            skid_d     = dec;
            if_ready_d = 1'b0;
          end else if (retire && !accept) begin
            state_d = StEmpty;
            out_d   = Bubble;
          end else if (retire && accept) begin
            out_d = dec;
          end
        end
        StSkid: begin
          if (retire) begin
            state_d    = StFull;
            out_d      = skid_q;
            skid_d     = Bubble;
            if_ready_d = 1'b1;
          end
        end
        default: begin
          state_d    = StEmpty;
          out_d      = Bubble;
          skid_d     = Bubble;
          if_ready_d = 1'b1;
        end
      endcase
    end
  end

  // State, output register, skid buffer and registered if_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      out_q      <= Bubble;
      skid_q     <= Bubble;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      if_ready_q <= if_ready_d;
    end
  end

  assign bus.if_ready    = if_ready_q;
  assign bus.ex_valid    = ex_valid;
  assign bus.ex_pc       = out_q.pc;
  assign bus.ex_instr    = ex_valid ? out_q.instr : NOP_INSTR;
  assign bus.ex_rs1_addr = out_q.rs1;
  assign bus.ex_rs2_addr = out_q.rs2;
  assign bus.ex_rd_addr  = out_q.rd;
  assign bus.ex_imm      = out_q.imm;
  assign bus.ex_funct3   = out_q.funct3;
  assign bus.ex_funct7_r = out_q.funct7_r;
  assign bus.ex_op_class = out_q.op_class;
  assign bus.ex_illegal  = out_q.illegal;

endmodule

// File: tb/tb_rv_id_decode.sv
// Self-checking bench for rv_id_decode: directed decode cases, skid/backpressure ordering,
// flush, asynchronous reset and a randomised stream checked against a scoreboard.
module tb_rv_id_decode;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [119:0] sb[$];
  logic [31:0]  pc_ctr = 32'h0001_0000;

  rv_id_decode_if #(.XLEN(32)) bus ();

  rv_id_decode #(
    .XLEN      (32),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [119:0] obs();
    return {bus.ex_pc, bus.ex_instr, bus.ex_rs1_addr, bus.ex_rs2_addr, bus.ex_rd_addr,
            bus.ex_imm, bus.ex_funct3, bus.ex_funct7_r, bus.ex_op_class, bus.ex_illegal};
  endfunction

  // Reference decode written from the ISA tables
  function automatic logic [119:0] model(input logic [31:0] pc, input logic [31:0] ins);
    logic [3:0]  cls;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        f7;
    logic        ill;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    fn3 = ins[14:12];
    fn7 = ins[31:25];
    cls = 4'd9;
    imm = 32'd0;
    f7  = 1'b0;
    ill = 1'b0;
    case (ins[6:0])
      7'h33: begin
        cls = 4'd0;
        f7  = ins[30];
        if (fn7 == 7'h20) ill = !(fn3 == 3'd0 || fn3 == 3'd5);
        else ill = (fn7 != 7'h00);
      end
      7'h13: begin
        cls = 4'd1;
        if (fn3 == 3'd1) begin
          imm = 32'(ins[24:20]);
          ill = (fn7 != 7'h00);
        end else if (fn3 == 3'd5) begin
          imm = 32'(ins[24:20]);
          f7  = ins[30];
          ill = (fn7 != 7'h00) && (fn7 != 7'h20);
        end else begin
          imm = 32'($signed(ins[31:20]));
        end
      end
      7'h03: begin cls = 4'd2; imm = 32'($signed(ins[31:20])); ill = (fn3 == 3) || (fn3 >= 6); end
      7'h23: begin cls = 4'd3; imm = 32'($signed({ins[31:25], ins[11:7]})); ill = (fn3 >= 3); end
      7'h63: begin
        cls = 4'd4;
        imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        ill = (fn3 == 2) || (fn3 == 3);
      end
      7'h6f: begin
        cls = 4'd5;
        imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin cls = 4'd6; imm = 32'($signed(ins[31:20])); ill = (fn3 != 0); end
      7'h37: begin cls = 4'd7; imm = ins & 32'hFFFF_F000; end
      7'h17: begin cls = 4'd8; imm = ins & 32'hFFFF_F000; end
      7'h0f, 7'h73: cls = 4'd9;
      default: ill = 1'b1;
    endcase
`ifdef RV_ID_ILLEGAL_CHK_EN
    if (ill) begin
      cls = 4'd15;
      imm = 32'd0;
      f7  = 1'b0;
    end
`else
    ill = 1'b0;
`endif
    rd = (cls == 3 || cls == 4 || cls == 9 || cls == 15) ? 5'd0 : ins[11:7];
    return {pc, ins, ins[19:15], ins[24:20], rd, imm, fn3, f7, cls, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_instr = ins;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.ex_valid); end
    total++;
    if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.if_ready); end
    total++;
    if (obs() !== {32'h0, NOP, 56'h0}) begin
      bad++;
      $display("FAIL reset_fields got=%h exp=%h", obs(), {32'h0, NOP, 56'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // One beat through an idle stage with EX always ready
  task automatic test_single(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [4:0] e_rs1, input logic [4:0] e_rd,
                             input logic [31:0] e_imm, input logic [2:0] e_f3, input logic e_f7,
                             input logic [3:0] e_cls, input logic e_ill);
    logic [50:0] got, exp;
    flush = 1'b0;
    bus.ex_ready = 1'b1;
    offer(pc, ins);
    @(negedge clk);
    total++;
    if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL %s_accept got=%b exp=1", nm, bus.if_ready); end
    tick();
    bus.if_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b exp=1", nm, bus.ex_valid); end
    got = {bus.ex_rs1_addr, bus.ex_rd_addr, bus.ex_imm, bus.ex_funct3, bus.ex_funct7_r,
           bus.ex_op_class, bus.ex_illegal};
    exp = {e_rs1, e_rd, e_imm, e_f3, e_f7, e_cls, e_ill};
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s_fields got=%h exp=%h", nm, got, exp); end
    total++;
    if (obs() !== model(pc, ins)) begin
      bad++;
      $display("FAIL %s_model got=%h exp=%h", nm, obs(), model(pc, ins));
    end
    tick();
    @(negedge clk);
    total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_instr !== NOP) begin
      bad++;
      $display("FAIL %s_drain got=%b/%h exp=0/%h", nm, bus.ex_valid, bus.ex_instr, NOP);
    end
    tick();
  endtask

  // Three beats against a stalled EX, then release and check order
  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    logic [119:0] exp;
    int retired;
    logic pend;
    pcs = '{32'h200, 32'h204, 32'h208};
    ins = '{32'h1234_53B7, 32'h0053_2423, 32'hFE00_0EE3};
    flush = 1'b0;
    bus.ex_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      offer(pcs[k], ins[k]);
      @(negedge clk);
      total++;
      if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept%0d got=%b exp=1", k, bus.if_ready); end
      sb.push_back(model(pcs[k], ins[k]));
      tick();
    end
    offer(pcs[2], ins[2]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL b2b_skid_ready got=%b exp=0", bus.if_ready); end
      total++;
      if (bus.ex_valid !== 1'b1 || obs() !== sb[0]) begin
        bad++;
        $display("FAIL b2b_stall_hold got=%b/%h exp=1/%h", bus.ex_valid, obs(), sb[0]);
      end
      tick();
    end
    bus.ex_ready = 1'b1;
    retired = 0;
    pend = 1'b1;
    for (int c = 0; c < 10 && retired < 3; c++) begin
      @(negedge clk);
      if (bus.ex_valid && bus.ex_ready) begin
        retired++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra got=%h exp=none", obs());
        end else begin
          exp = sb.pop_front();
          if (obs() !== exp) begin bad++; $display("FAIL b2b_order got=%h exp=%h", obs(), exp); end
        end
      end
      if (bus.if_valid && bus.if_ready) begin
        sb.push_back(model(pcs[2], ins[2]));
        pend = 1'b0;
      end
      tick();
      if (!pend) bus.if_valid = 1'b0;
    end
    total++;
    if (retired != 3 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got=%0d/%0d exp=3/0", retired, sb.size());
    end
    sb.delete();
    bus.if_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", bus.ex_valid); end
    tick();
  endtask

  // Flush while SKID holds two beats and a third is offered
  task automatic test_flush();
    logic seen;
    bus.ex_ready = 1'b0;
    flush = 1'b0;
    offer(32'h400, 32'h0010_0093);
    tick();
    offer(32'h404, 32'h0020_0113);
    tick();
    offer(32'h408, 32'h0030_0193);
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL flush_in_skid got=%b exp=0", bus.if_ready); end
    tick();
    flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.ex_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_state got=%b/%b exp=0/1", bus.ex_valid, bus.if_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      if (bus.ex_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b exp=0", seen); end
    tick();
    offer(32'h7000, 32'h0000_006F);
    @(negedge clk);
    tick();
    bus.if_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== model(32'h7000, 32'h0000_006F)) begin
      bad++;
      $display("FAIL flush_next got=%b/%h exp=1/%h", bus.ex_valid, obs(),
               model(32'h7000, 32'h0000_006F));
    end
    tick();
  endtask

  // Asynchronous reset asserted between edges while in SKID
  task automatic test_async_reset();
    bus.ex_ready = 1'b0;
    flush = 1'b0;
    offer(32'h800, 32'h0010_0093);
    tick();
    offer(32'h804, 32'h0020_0113);
    tick();
    bus.if_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL rst_pre_skid got=%b exp=0", bus.if_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.ex_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_async got=%b/%b exp=0/1", bus.ex_valid, bus.if_ready);
    end
    total++;
    if (obs() !== {32'h0, NOP, 56'h0}) begin
      bad++;
      $display("FAIL rst_async_fields got=%h exp=%h", obs(), {32'h0, NOP, 56'h0});
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.ex_ready = 1'b1;
    offer(32'h900, 32'hFFF1_0093);
    @(negedge clk);
    tick();
    bus.if_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== model(32'h900, 32'hFFF1_0093)) begin
      bad++;
      $display("FAIL rst_first_beat got=%b/%h exp=1/%h", bus.ex_valid, obs(),
               model(32'h900, 32'hFFF1_0093));
    end
    tick();
  endtask

  // Random valid/ready/flush traffic checked through the scoreboard
  task automatic test_random_stream();
    logic [6:0] opt [12];
    logic [31:0] ins;
    logic [119:0] exp, prev;
    logic hold, stall;
    opt = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73, 7'h00};
    sb.delete();
    hold = 1'b0;
    stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        ins = $urandom;
        if ($urandom_range(0, 9) != 0) ins[6:0] = opt[$urandom_range(0, 11)];
        if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        bus.if_valid = ($urandom_range(0, 9) < 7);
        bus.if_pc = pc_ctr;
        bus.if_instr = ins;
        pc_ctr = pc_ctr + 32'd4;
      end
      bus.ex_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      if (stall && bus.ex_valid) begin
        total++;
        if (obs() !== prev) begin bad++; $display("FAIL rnd_stall_hold got=%h exp=%h", obs(), prev); end
      end
      if (!bus.ex_valid) begin
        total++;
        if (bus.ex_instr !== NOP) begin bad++; $display("FAIL rnd_nop got=%h exp=%h", bus.ex_instr, NOP); end
      end
      if (bus.ex_valid && bus.ex_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra got=%h exp=none", obs());
        end else begin
          exp = sb.pop_front();
          if (obs() !== exp) begin bad++; $display("FAIL rnd_beat got=%h exp=%h", obs(), exp); end
        end
      end
      if (flush) sb.delete();
      else if (bus.if_valid && bus.if_ready) sb.push_back(model(bus.if_pc, bus.if_instr));
      hold = bus.if_valid && !bus.if_ready && !flush;
      stall = bus.ex_valid && !bus.ex_ready && !flush;
      prev = obs();
      tick();
    end
    flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.ex_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rnd_drain_extra got=%h exp=none", obs());
        end else begin
          exp = sb.pop_front();
          if (obs() !== exp) begin bad++; $display("FAIL rnd_drain got=%h exp=%h", obs(), exp); end
        end
      end
      tick();
    end
    total++;
    if (sb.size() != 0 || bus.ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL rnd_lost got=%0d/%b exp=0/0", sb.size(), bus.ex_valid);
    end
  endtask

  initial begin
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_instr = '0;
    bus.ex_ready = 1'b0;
    test_reset();
    test_single("addi_neg", 32'h100, 32'hFFF1_0093, 5'd2, 5'd1, 32'hFFFF_FFFF, 3'd0, 1'b0, 4'd1,
                1'b0);
    test_single("srai", 32'h104, 32'h4072_5193, 5'd4, 5'd3, 32'h0000_0007, 3'd5, 1'b1, 4'd1,
                1'b0);
    test_single("addi_400", 32'h108, 32'h4003_0293, 5'd6, 5'd5, 32'h0000_0400, 3'd0, 1'b0, 4'd1,
                1'b0);
`ifdef RV_ID_ILLEGAL_CHK_EN
    test_single("zero_word", 32'h10C, 32'h0, 5'd0, 5'd0, 32'h0, 3'd0, 1'b0, 4'd15, 1'b1);
`else
    test_single("zero_word", 32'h10C, 32'h0, 5'd0, 5'd0, 32'h0, 3'd0, 1'b0, 4'd9, 1'b0);
`endif
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
